// File: rtl/alu_rmw_sequencer.sv
// Read-modify-write sequencer around the combinational alu: fetches a byte-wise memory
// operand, runs one alu cycle, optionally writes the result back, and reports result/flags.
module alu_rmw_sequencer #(
  parameter int ADDR_WIDTH  = 24,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4:0]            op_i,
  input  logic                  size_i,
  input  logic                  mem_is_a_i,
  input  logic                  wb_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [15:0]           reg_i,
  input  logic                  c_i,
  input  logic                  d_i,
  output logic [4:0]            alu_op,
  output logic                  alu_size,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic                  alu_c,
  output logic                  alu_d,
  input  logic [15:0]           alu_r,
  input  logic [3:0]            alu_flags,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           result,
  output logic [3:0]            flags_out,
  output logic                  flags_we
);

  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_EXEC, S_WR_LO, S_WR_HI, S_DONE, S_ERR
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic [4:0]            op_reg;
  logic                  size_reg, mem_is_a_reg, wb_reg, c_reg, d_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [15:0]           reg_val_reg;
  logic [15:0]           mem_val;
  logic [15:0]           result_reg;
  logic [3:0]            flags_reg;
  logic                  hi_byte;
  logic                  accept;

  assign accept = (state_reg == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    bus_req       = 1'b0;
    bus_we        = 1'b0;
    bus_wdata     = 8'h00;
    hi_byte       = 1'b0;
    unique case (state_reg)
      S_IDLE:  if (start) state_next = S_RD_LO;
      S_RD_LO: begin
        bus_req = 1'b1;
        if (bus_ack) state_next = size_reg ? S_RD_HI : S_EXEC;
      end
      S_RD_HI: begin
        bus_req = 1'b1;
        hi_byte = 1'b1;
        if (bus_ack) state_next = S_EXEC;
      end
      S_EXEC:  state_next = wb_reg ? S_WR_LO : S_DONE;
      S_WR_LO: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_wdata = result_reg[7:0];
        if (bus_ack) state_next = size_reg ? S_WR_HI : S_DONE;
      end
      S_WR_HI: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        hi_byte   = 1'b1;
        bus_wdata = result_reg[15:8];
        if (bus_ack) state_next = S_DONE;
      end
      S_DONE, S_ERR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // An ack on the last permitted wait cycle still wins over the abort.
    if (bus_req && !bus_ack) begin
      if (wait_cnt_reg == WAIT_LAST) state_next = S_ERR;
      else                           wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    bus_addr = '0;
    if (bus_req) bus_addr = hi_byte ? addr_reg + ADDR_WIDTH'(1) : addr_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_reg       <= '0;
      size_reg     <= 1'b0;
      mem_is_a_reg <= 1'b0;
      wb_reg       <= 1'b0;
      c_reg        <= 1'b0;
      d_reg        <= 1'b0;
      addr_reg     <= '0;
      reg_val_reg  <= '0;
      result_reg   <= '0;
      flags_reg    <= '0;
    end else begin
      if (accept) begin
        op_reg       <= op_i;
        size_reg     <= size_i;
        mem_is_a_reg <= mem_is_a_i;
        wb_reg       <= wb_i;
        c_reg        <= c_i;
        d_reg        <= d_i;
        addr_reg     <= addr_i;
        reg_val_reg  <= reg_i;
      end
      if (state_reg == S_EXEC) begin
        result_reg <= alu_r;
        flags_reg  <= alu_flags;
      end
    end
  end

  // Memory operand byte lanes; both clear on start so 8-bit operands read as zero-extended.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam state_t LANE_STATE = (gi == 0) ? S_RD_LO : S_RD_HI;
    logic [7:0] byte_reg;
    always_ff @(posedge clk) begin
      if (!reset_n)                                byte_reg <= 8'h00;
      else if (accept)                             byte_reg <= 8'h00;
      else if (state_reg == LANE_STATE && bus_ack) byte_reg <= bus_rdata;
    end
  end

  assign mem_val   = {g_lane[1].byte_reg, g_lane[0].byte_reg};
  assign alu_op    = op_reg;
  assign alu_size  = size_reg;
  assign alu_a     = mem_is_a_reg ? mem_val : reg_val_reg;
  assign alu_b     = mem_is_a_reg ? reg_val_reg : mem_val;
  assign alu_c     = c_reg;
  assign alu_d     = d_reg;
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE) || (state_reg == S_ERR);
  assign err       = (state_reg == S_ERR);
  assign flags_we  = (state_reg == S_DONE);
  assign result    = result_reg;
  assign flags_out = flags_reg;

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Directed bench for alu_rmw_sequencer: small alu model, waitable bus slave with ack blocking,
// table of hand-computed transactions plus timeout, reset-abort and start-while-busy sequences.
module tb_alu_rmw_sequencer;
  localparam int TMO = 6;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] op_i = '0;
  logic size_i = 1'b0, mem_is_a_i = 1'b0, wb_i = 1'b0, c_i = 1'b0, d_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [15:0] reg_i = '0;
  logic [4:0] alu_op;
  logic alu_size, alu_c, alu_d;
  logic [15:0] alu_a, alu_b, alu_r;
  logic [3:0] alu_flags;
  logic bus_req, bus_we, bus_ack;
  logic [23:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic busy, done, err, flags_we;
  logic [15:0] result;
  logic [3:0] flags_out;

  alu_rmw_sequencer #(.ADDR_WIDTH(24), .BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_i(op_i), .size_i(size_i),
    .mem_is_a_i(mem_is_a_i), .wb_i(wb_i), .addr_i(addr_i), .reg_i(reg_i), .c_i(c_i), .d_i(d_i),
    .alu_op(alu_op), .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_d(alu_d), .alu_r(alu_r), .alu_flags(alu_flags), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .done(done), .err(err), .result(result), .flags_out(flags_out),
    .flags_we(flags_we)
  );

  always #5 clk = ~clk;

  // Reference alu: ADD = A+B+C, SUB = A+~B+C; flags {S,V,C,Z}.
  always_comb begin
    logic [16:0] s16;
    logic [8:0]  s8;
    logic [15:0] bb;
    bb = (alu_op == OP_SUB) ? ~alu_b : alu_b;
    s16 = {1'b0, alu_a} + {1'b0, bb} + {16'h0, alu_c};
    s8  = {1'b0, alu_a[7:0]} + {1'b0, bb[7:0]} + {8'h0, alu_c};
    if (alu_size) begin
      alu_r = s16[15:0];
      alu_flags = {s16[15], (alu_a[15] == bb[15]) && (s16[15] != alu_a[15]), s16[16], s16[15:0] == 16'h0};
    end else begin
      alu_r = {8'h00, s8[7:0]};
      alu_flags = {s8[7], (alu_a[7] == bb[7]) && (s8[7] != alu_a[7]), s8[8], s8[7:0] == 8'h0};
    end
  end

  // Bus slave: memory indexed by the low 16 address bits, programmable wait states and ack blocking.
  logic [7:0]  mem [0:65535];
  int          slave_wait = 0;
  int          wait_ctr = 0;
  int          wr_count = 0;
  logic        blk_en = 1'b0, blk_we = 1'b0;
  logic [23:0] blk_addr = '0;
  logic [23:0] last_rd_addr = '0, last_wr_addr = '0;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always_comb begin
    bus_rdata = mem[bus_addr[15:0]];
    bus_ack = bus_req && (wait_ctr >= slave_wait) &&
              !(blk_en && bus_addr == blk_addr && bus_we == blk_we);
  end

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus_req && bus_ack) begin
      if (bus_we) begin
        mem[bus_addr[15:0]] <= bus_wdata;
        wr_count <= wr_count + 1;
        last_wr_addr <= bus_addr;
      end else begin
        last_rd_addr <= bus_addr;
      end
    end
    wait_ctr <= (bus_req && !bus_ack) ? wait_ctr + 1 : 0;
  end

  typedef struct {
    logic [4:0] op; logic size, mem_is_a, wb, c, d;
    logic [23:0] addr; logic [15:0] regv; logic [7:0] lo, hi; int waits;
    logic [15:0] exp_a, exp_b, exp_r; logic [3:0] exp_f; int exp_lat;
    logic [7:0] exp_wlo, exp_whi; logic [23:0] exp_raddr, exp_waddr;
  } vec_t;

  vec_t vecs [7];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    op_i = v.op; size_i = v.size; mem_is_a_i = v.mem_is_a; wb_i = v.wb;
    c_i = v.c; d_i = v.d; addr_i = v.addr; reg_i = v.regv;
  endtask

  task automatic run_row(input int k);
    vec_t v;
    logic [23:0] hia;
    int cyc, wc0;
    bit seen;
    v = vecs[k];
    hia = v.addr + 24'd1;
    preload(v.addr[15:0], v.lo);
    preload(hia[15:0], v.hi);
    slave_wait = v.waits;
    wc0 = wr_count;
    @(negedge clk);
    drive(v); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin seen = 1; break; end
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    chk($sformatf("row%0d done_seen", k), 32'(seen), 32'd1);
    $display("row %0d op=%0d size=%0d wb=%0d result=%h flags=%b cycles=%0d",
             k, v.op, v.size, v.wb, result, flags_out, cyc);
    if (seen) begin
      chk($sformatf("row%0d latency", k), 32'(cyc), 32'(v.exp_lat));
      chk($sformatf("row%0d result", k), 32'(result), 32'(v.exp_r));
      chk($sformatf("row%0d flags", k), 32'(flags_out), 32'(v.exp_f));
      chk($sformatf("row%0d flags_we", k), 32'(flags_we), 32'd1);
      chk($sformatf("row%0d err", k), 32'(err), 32'd0);
      chk($sformatf("row%0d alu_a", k), 32'(alu_a), 32'(v.exp_a));
      chk($sformatf("row%0d alu_b", k), 32'(alu_b), 32'(v.exp_b));
      chk($sformatf("row%0d alu_cd", k), 32'({alu_c, alu_d}), 32'({v.c, v.d}));
      chk($sformatf("row%0d rd_addr", k), 32'(last_rd_addr), 32'(v.exp_raddr));
    end
    @(negedge clk);
    chk($sformatf("row%0d idle_after", k), 32'({busy, done}), 32'd0);
    chk($sformatf("row%0d writes", k), 32'(wr_count - wc0), v.wb ? (v.size ? 32'd2 : 32'd1) : 32'd0);
    if (v.wb) begin
      chk($sformatf("row%0d wr_lo", k), 32'(mem[v.addr[15:0]]), 32'(v.exp_wlo));
      chk($sformatf("row%0d wr_addr", k), 32'(last_wr_addr), 32'(v.exp_waddr));
      if (v.size) chk($sformatf("row%0d wr_hi", k), 32'(mem[hia[15:0]]), 32'(v.exp_whi));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone, dcyc;
    bit seen;
    //          op     sz ma wb c  d  addr        reg       lo     hi    w  exp_a     exp_b     exp_r     flags  lat wlo    whi    raddr       waddr
    vecs[0] = '{OP_ADD, 0, 1, 1, 0, 0, 24'h001000, 16'h0001, 8'h7F, 8'h55, 0, 16'h007F, 16'h0001, 16'h0080, 4'b1100, 4, 8'h80, 8'h00, 24'h001000, 24'h001000};
    vecs[1] = '{OP_SUB, 1, 1, 0, 1, 0, 24'h002000, 16'h1234, 8'h34, 8'h12, 0, 16'h1234, 16'h1234, 16'h0000, 4'b0011, 4, 8'h00, 8'h00, 24'h002001, 24'h000000};
    vecs[2] = '{OP_ADD, 1, 0, 1, 0, 0, 24'hFFFFFF, 16'h0101, 8'h01, 8'h80, 0, 16'h0101, 16'h8001, 16'h8102, 4'b1000, 6, 8'h02, 8'h81, 24'h000000, 24'h000000};
    vecs[3] = '{OP_ADD, 0, 1, 0, 0, 1, 24'h003000, 16'h0001, 8'hFF, 8'hAA, 2, 16'h00FF, 16'h0001, 16'h0000, 4'b0011, 5, 8'h00, 8'h00, 24'h003000, 24'h000000};
    vecs[4] = '{OP_SUB, 0, 0, 1, 1, 0, 24'h004000, 16'h0020, 8'h08, 8'h00, 1, 16'h0020, 16'h0008, 16'h0018, 4'b0010, 6, 8'h18, 8'h00, 24'h004000, 24'h004000};
    vecs[5] = '{OP_ADD, 1, 0, 1, 0, 1, 24'h005000, 16'h7FFF, 8'h01, 8'h00, 0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 6, 8'h00, 8'h80, 24'h005001, 24'h005001};
    vecs[6] = '{OP_ADD, 0, 1, 0, 0, 0, 24'h007000, 16'h0003, 8'h05, 8'h00, 5, 16'h0005, 16'h0003, 16'h0008, 4'b0000, 8, 8'h00, 8'h00, 24'h007000, 24'h000000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy/done/err/fwe", 32'({busy, done, err, flags_we}), 32'd0);
    chk("rst bus_req/we", 32'({bus_req, bus_we}), 32'd0);
    chk("rst bus_addr", 32'(bus_addr), 32'd0);
    chk("rst bus_wdata", 32'(bus_wdata), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags_out", 32'(flags_out), 32'd0);
    chk("rst alu_ab", {alu_a, alu_b}, 32'd0);
    chk("rst alu_op/size/c/d", 32'({alu_op, alu_size, alu_c, alu_d}), 32'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run_row(k);

    // Timeout in RD_HI: held result, err pulse, no flags_we
    preload(16'h6000, 8'h11);
    preload(16'h6001, 8'h22);
    slave_wait = 0; blk_en = 1'b1; blk_we = 1'b0; blk_addr = 24'h006001;
    @(negedge clk);
    drive(vecs[1]); addr_i = 24'h006000; start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1; break; end
      if (cyc == 5) chk("tmo stall addr", 32'({bus_req, bus_addr}), 32'({1'b1, 24'h006001}));
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    $display("timeout op: done=%0d err=%0d cycles=%0d", done, err, cyc);
    chk("tmo done_seen", 32'(seen), 32'd1);
    chk("tmo latency", 32'(cyc), 32'(2 + TMO));
    chk("tmo err/flags_we", 32'({err, flags_we}), 32'b10);
    chk("tmo result held", 32'(result), 32'(vecs[6].exp_r));
    chk("tmo flags held", 32'(flags_out), 32'(vecs[6].exp_f));
    @(negedge clk);
    chk("tmo idle_after", 32'({busy, done, err}), 32'd0);
    blk_en = 1'b0;
    run_row(0);

    // start pulsed while busy (with different fields) and during the DONE cycle
    preload(16'h7000, 8'h05);
    slave_wait = 0;
    @(negedge clk);
    drive(vecs[6]); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk);
    op_i = OP_SUB; reg_i = 16'h0001; addr_i = 24'h003000;
    @(posedge clk); cyc = 2;
    @(negedge clk);
    start = 1'b0; ndone = 0; dcyc = 0;
    for (int i = 0; i < 12; i++) begin
      start = 1'b0;
      if (done) begin
        ndone++;
        dcyc = cyc;
        start = 1'b1;
      end
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    $display("start-while-busy: dones=%0d first_done_cycle=%0d result=%h", ndone, dcyc, result);
    chk("busy_start done_count", 32'(ndone), 32'd1);
    chk("busy_start latency", 32'(dcyc), 32'd3);
    chk("busy_start result", 32'(result), 32'h0008);
    chk("busy_start idle", 32'(busy), 32'd0);

    // reset_n asserted while a write waits for ack
    preload(16'h8000, 8'h10);
    blk_en = 1'b1; blk_we = 1'b1; blk_addr = 24'h008000;
    cyc = wr_count;
    @(negedge clk);
    drive(vecs[0]); addr_i = 24'h008000; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_req && bus_we) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("rstwr reached WR_LO", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("reset during write: bus_req=%0d busy=%0d done=%0d", bus_req, busy, done);
    chk("rstwr bus_req", 32'(bus_req), 32'd0);
    chk("rstwr busy/done/fwe", 32'({busy, done, flags_we}), 32'd0);
    chk("rstwr result cleared", 32'(result), 32'd0);
    reset_n = 1'b1; blk_en = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("rstwr no done", 32'(ndone), 32'd0);
    chk("rstwr no write", 32'(wr_count - cyc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
